// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer slice: default geometry and the
// "no destination register" encoding used by dispatch and the regfile.
// Latency: n/a. Backpressure: n/a.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEF  = 16;
    localparam int ROB_TAG_W_DEF  = 4;
    localparam int ROB_DATA_W_DEF = 32;
    localparam int ROB_REG_W_DEF  = 5;
    localparam int ROB_PC_W       = 32;

    // Destination 0 means "no architectural write"; the regfile drops it.
    localparam logic [ROB_REG_W_DEF-1:0] ROB_NO_DEST = '0;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's dispatch, writeback, query, commit and flush signals.
// Latency: n/a (wires only). Backpressure: alloc_ready gates allocation; rdy freezes the ROB.
// master = pipeline side (ID/EX/dispatch), slave = reorder buffer.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W  = ROB_TAG_W_DEF,
    parameter int DATA_W = ROB_DATA_W_DEF,
    parameter int REG_W  = ROB_REG_W_DEF
) ();

    logic                rdy;

    logic                alloc_valid;
    logic [REG_W-1:0]    alloc_dest;
    logic                alloc_ready;
    logic [TAG_W-1:0]    alloc_tag;

    logic                wb_valid;
    logic [TAG_W-1:0]    wb_tag;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_mispredict;
    logic [ROB_PC_W-1:0] wb_target_pc;

    logic [TAG_W-1:0]    q1_tag;
    logic [TAG_W-1:0]    q2_tag;
    logic                q1_ready;
    logic                q2_ready;
    logic [DATA_W-1:0]   q1_data;
    logic [DATA_W-1:0]   q2_data;

    logic                commit_valid;
    logic [REG_W-1:0]    commit_reg_dest;
    logic [TAG_W-1:0]    commit_tag;
    logic [DATA_W-1:0]   commit_data;

    logic                clear;
    logic [ROB_PC_W-1:0] clear_pc;

    modport master (
        output rdy, alloc_valid, alloc_dest,
               wb_valid, wb_tag, wb_data, wb_mispredict, wb_target_pc,
               q1_tag, q2_tag,
        input  alloc_ready, alloc_tag, q1_ready, q1_data, q2_ready, q2_data,
               commit_valid, commit_reg_dest, commit_tag, commit_data,
               clear, clear_pc
    );

    modport slave (
        input  rdy, alloc_valid, alloc_dest,
               wb_valid, wb_tag, wb_data, wb_mispredict, wb_target_pc,
               q1_tag, q2_tag,
        output alloc_ready, alloc_tag, q1_ready, q1_data, q2_ready, q2_data,
               commit_valid, commit_reg_dest, commit_tag, commit_data,
               clear, clear_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures writeback, retires one entry/cycle.
// Latency: writeback->commit 2 edges (no bypass into commit); commit/clear outputs registered.
// Backpressure: alloc_ready=0 when full; rdy=0 freezes all state and holds outputs.
//
// Ports: clk, rst (synchronous, active-high, highest priority), rob (reorder_buffer_if.slave):
//   alloc_*  : issue request / granted tag (tag == tail index)
//   wb_*     : result capture, mispredict flag and correct target PC
//   q1_/q2_* : combinational operand lookup by tag
//   commit_* : registered regfile write port
//   clear/clear_pc : registered one-cycle flush pulse on committing a mispredicted branch
// Build option ROB_WB_BYPASS_EN: forward same-cycle writeback into queries and let
//   alloc_ready see a same-cycle commit when full.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int TAG_W     = ROB_TAG_W_DEF,
    parameter int DATA_W    = ROB_DATA_W_DEF,
    parameter int REG_W     = ROB_REG_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);

    localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(ROB_DEPTH);

    // Entry storage
    logic                r_busy  [ROB_DEPTH];
    logic                r_ready [ROB_DEPTH];
    logic                r_misp  [ROB_DEPTH];
    logic [REG_W-1:0]    r_dest  [ROB_DEPTH];
    logic [DATA_W-1:0]   r_data  [ROB_DEPTH];
    logic [ROB_PC_W-1:0] r_tpc   [ROB_DEPTH];

    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic                r_commit_valid;
    logic [REG_W-1:0]    r_commit_dest;
    logic [TAG_W-1:0]    r_commit_tag;
    logic [DATA_W-1:0]   r_commit_data;
    logic                r_clear;
    logic [ROB_PC_W-1:0] r_clear_pc;

    logic                w_commit_fire;
    logic                w_flush;
    logic                w_alloc_ready;
    logic                w_alloc_fire;
    logic                w_wb_fire;
    logic                w_q1_ready;
    logic                w_q2_ready;
    logic [DATA_W-1:0]   w_q1_data;
    logic [DATA_W-1:0]   w_q2_data;

    // Commit looks only at registered entry state, so a writeback landing on the
    // head this cycle retires one cycle later.
    assign w_commit_fire = rob.rdy & r_busy[r_head] & r_ready[r_head];
    assign w_flush       = w_commit_fire & r_misp[r_head];

`ifdef ROB_WB_BYPASS_EN
    // A non-flushing commit frees the head slot at this edge, so a full ROB can
    // still accept one allocation (it lands in the slot being retired).
    assign w_alloc_ready = (r_count != L_FULL) | (w_commit_fire & ~w_flush);
`else
    assign w_alloc_ready = (r_count != L_FULL);
`endif

    // While clear is high the front end is refetching: ignore its requests.
    assign w_alloc_fire = rob.alloc_valid & w_alloc_ready & rob.rdy & ~r_clear & ~w_flush;
    assign w_wb_fire    = rob.wb_valid & r_busy[rob.wb_tag] & rob.rdy & ~r_clear;

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rob.rdy) begin
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_alloc_fire)  r_tail <= r_tail + TAG_W'(1);
                if (w_commit_fire) r_head <= r_head + TAG_W'(1);
                case ({w_alloc_fire, w_commit_fire})
                    2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                    2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry state. Allocation is applied last so that, at full with bypass,
    // the slot retired this edge is immediately re-owned by the new entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
                r_misp[i]  <= 1'b0;
                r_dest[i]  <= ROB_NO_DEST;
                r_data[i]  <= '0;
                r_tpc[i]   <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else begin
            if (w_commit_fire) begin
                r_busy[r_head] <= 1'b0;
            end
            if (w_wb_fire) begin
                r_ready[rob.wb_tag] <= 1'b1;
                r_data[rob.wb_tag]  <= rob.wb_data;
                r_misp[rob.wb_tag]  <= rob.wb_mispredict;
                r_tpc[rob.wb_tag]   <= rob.wb_target_pc;
            end
            if (w_alloc_fire) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_misp[r_tail]  <= 1'b0;
                r_dest[r_tail]  <= rob.alloc_dest;
            end
        end
    end

    // Commit port and flush pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_valid <= 1'b0;
            r_commit_dest  <= '0;
            r_commit_tag   <= '0;
            r_commit_data  <= '0;
            r_clear        <= 1'b0;
            r_clear_pc     <= '0;
        end else if (rob.rdy) begin
            r_commit_valid <= w_commit_fire;
            r_clear        <= w_flush;
            if (w_commit_fire) begin
                r_commit_dest <= r_dest[r_head];
                r_commit_tag  <= r_head;
                r_commit_data <= r_data[r_head];
            end
            if (w_flush) begin
                r_clear_pc <= r_tpc[r_head];
            end
        end
    end

    // Operand queries
    always_comb begin
        w_q1_ready = r_busy[rob.q1_tag] & r_ready[rob.q1_tag];
        w_q1_data  = r_busy[rob.q1_tag] ? r_data[rob.q1_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (w_wb_fire && (rob.wb_tag == rob.q1_tag)) begin
            w_q1_ready = 1'b1;
            w_q1_data  = rob.wb_data;
        end
`endif
    end

    always_comb begin
        w_q2_ready = r_busy[rob.q2_tag] & r_ready[rob.q2_tag];
        w_q2_data  = r_busy[rob.q2_tag] ? r_data[rob.q2_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (w_wb_fire && (rob.wb_tag == rob.q2_tag)) begin
            w_q2_ready = 1'b1;
            w_q2_data  = rob.wb_data;
        end
`endif
    end

    assign rob.alloc_ready     = w_alloc_ready;
    assign rob.alloc_tag       = r_tail;
    assign rob.q1_ready        = w_q1_ready;
    assign rob.q1_data         = w_q1_data;
    assign rob.q2_ready        = w_q2_ready;
    assign rob.q2_data         = w_q2_data;
    assign rob.commit_valid    = r_commit_valid;
    assign rob.commit_reg_dest = r_commit_dest;
    assign rob.commit_tag      = r_commit_tag;
    assign rob.commit_data     = r_commit_data;
    assign rob.clear           = r_clear;
    assign rob.clear_pc        = r_clear_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (both ROB_WB_BYPASS_EN builds).
// Inputs are driven 1ns after the rising edge; outputs are sampled in the same window.
// Summary: "<passed>/<total> checks passed".
module tb_reorder_buffer;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    reorder_buffer_if rob_if ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_if.rdy           = 1'b1;
        rob_if.alloc_valid   = 1'b0;
        rob_if.alloc_dest    = '0;
        rob_if.wb_valid      = 1'b0;
        rob_if.wb_tag        = '0;
        rob_if.wb_data       = '0;
        rob_if.wb_mispredict = 1'b0;
        rob_if.wb_target_pc  = '0;
        rob_if.q1_tag        = '0;
        rob_if.q2_tag        = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] dest);
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_dest  = dest;
        tick();
        rob_if.alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] data,
                         input logic misp, input logic [31:0] pc);
        rob_if.wb_valid      = 1'b1;
        rob_if.wb_tag        = tag;
        rob_if.wb_data       = data;
        rob_if.wb_mispredict = misp;
        rob_if.wb_target_pc  = pc;
        tick();
        rob_if.wb_valid      = 1'b0;
        rob_if.wb_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        rob_if.alloc_valid = 1'b1;   // must be ignored under reset
        rob_if.alloc_dest  = 5'd9;
        tick();
        tick();
        rob_if.alloc_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL rst_commit_valid got=%0h exp=0", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_tag !== 4'd0) $display("FAIL rst_commit_tag got=%0h exp=0", rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_data !== 32'd0) $display("FAIL rst_commit_data got=%0h exp=0", rob_if.commit_data); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd0) $display("FAIL rst_commit_dest got=%0h exp=0", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.clear !== 1'b0) $display("FAIL rst_clear got=%0h exp=0", rob_if.clear); else passed++;
        checks++; if (rob_if.clear_pc !== 32'd0) $display("FAIL rst_clear_pc got=%0h exp=0", rob_if.clear_pc); else passed++;
        checks++; if (rob_if.alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready got=%0h exp=1", rob_if.alloc_ready); else passed++;
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL rst_alloc_tag got=%0h exp=0", rob_if.alloc_tag); else passed++;
    endtask

    task automatic test_in_order();
        apply_reset();
        do_alloc(5'd1);
        checks++; if (rob_if.alloc_tag !== 4'd1) $display("FAIL io_tag1 got=%0h exp=1", rob_if.alloc_tag); else passed++;
        do_alloc(5'd2);
        checks++; if (rob_if.alloc_tag !== 4'd2) $display("FAIL io_tag2 got=%0h exp=2", rob_if.alloc_tag); else passed++;
        do_alloc(5'd3);
        do_wb(4'd2, 32'h22, 1'b0, 32'h0);
        do_wb(4'd1, 32'h11, 1'b0, 32'h0);
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL io_head_not_ready got=%0h exp=0", rob_if.commit_valid); else passed++;
        do_wb(4'd0, 32'hAA, 1'b0, 32'h0);
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL io_no_bypass_commit got=%0h exp=0", rob_if.commit_valid); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1) $display("FAIL io_c0_valid got=%0h exp=1", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_tag !== 4'd0) $display("FAIL io_c0_tag got=%0h exp=0", rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd1) $display("FAIL io_c0_dest got=%0h exp=1", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.commit_data !== 32'hAA) $display("FAIL io_c0_data got=%0h exp=aa", rob_if.commit_data); else passed++;
        tick();
        checks++; if (rob_if.commit_tag !== 4'd1) $display("FAIL io_c1_tag got=%0h exp=1", rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd2) $display("FAIL io_c1_dest got=%0h exp=2", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.commit_data !== 32'h11) $display("FAIL io_c1_data got=%0h exp=11", rob_if.commit_data); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1) $display("FAIL io_c2_valid got=%0h exp=1", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd3) $display("FAIL io_c2_dest got=%0h exp=3", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.commit_data !== 32'h22) $display("FAIL io_c2_data got=%0h exp=22", rob_if.commit_data); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL io_drained got=%0h exp=0", rob_if.commit_valid); else passed++;
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            checks++; if (rob_if.alloc_ready !== 1'b1) $display("FAIL fw_ready_%0d got=%0h exp=1", i, rob_if.alloc_ready); else passed++;
            checks++; if (rob_if.alloc_tag !== 4'(i)) $display("FAIL fw_tag_%0d got=%0h exp=%0h", i, rob_if.alloc_tag, 4'(i)); else passed++;
            do_alloc(5'(i + 1));
        end
        checks++; if (rob_if.alloc_ready !== 1'b0) $display("FAIL fw_full got=%0h exp=0", rob_if.alloc_ready); else passed++;
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL fw_full_tag got=%0h exp=0", rob_if.alloc_tag); else passed++;
        do_alloc(5'd31);   // refused: ROB full
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL fw_refused got=%0h exp=0", rob_if.alloc_tag); else passed++;
        do_wb(4'd0, 32'h1234, 1'b0, 32'h0);
        checks++; if (rob_if.alloc_ready !== BYP) $display("FAIL fw_ready_commit_cycle got=%0h exp=%0h", rob_if.alloc_ready, BYP); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1) $display("FAIL fw_commit_valid got=%0h exp=1", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_data !== 32'h1234) $display("FAIL fw_commit_data got=%0h exp=1234", rob_if.commit_data); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd1) $display("FAIL fw_commit_dest got=%0h exp=1", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.alloc_ready !== 1'b1) $display("FAIL fw_ready_after got=%0h exp=1", rob_if.alloc_ready); else passed++;
        do_alloc(5'd20);   // takes wrapped tag 0
        checks++; if (rob_if.alloc_tag !== 4'd1) $display("FAIL fw_wrap_tag got=%0h exp=1", rob_if.alloc_tag); else passed++;
        checks++; if (rob_if.alloc_ready !== 1'b0) $display("FAIL fw_refull got=%0h exp=0", rob_if.alloc_ready); else passed++;
    endtask

    task automatic test_mispredict();
        apply_reset();
        do_alloc(5'd5);
        do_alloc(5'd6);
        do_alloc(5'd7);
        do_alloc(5'd8);
        do_wb(4'd1, 32'h5000, 1'b1, 32'h100);
        do_wb(4'd0, 32'hA0, 1'b0, 32'h0);
        do_wb(4'd2, 32'hC2, 1'b0, 32'h0);
        checks++; if (rob_if.commit_tag !== 4'd0 || rob_if.commit_valid !== 1'b1) $display("FAIL mp_c0 got=%0h/%0h exp=1/0", rob_if.commit_valid, rob_if.commit_tag); else passed++;
        checks++; if (rob_if.clear !== 1'b0) $display("FAIL mp_c0_clear got=%0h exp=0", rob_if.clear); else passed++;
        do_wb(4'd3, 32'hC3, 1'b0, 32'h0);
        checks++; if (rob_if.commit_valid !== 1'b1) $display("FAIL mp_c1_valid got=%0h exp=1", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_tag !== 4'd1) $display("FAIL mp_c1_tag got=%0h exp=1", rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd6) $display("FAIL mp_c1_dest got=%0h exp=6", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.commit_data !== 32'h5000) $display("FAIL mp_c1_data got=%0h exp=5000", rob_if.commit_data); else passed++;
        checks++; if (rob_if.clear !== 1'b1) $display("FAIL mp_clear got=%0h exp=1", rob_if.clear); else passed++;
        checks++; if (rob_if.clear_pc !== 32'h100) $display("FAIL mp_clear_pc got=%0h exp=100", rob_if.clear_pc); else passed++;
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL mp_tail_reset got=%0h exp=0", rob_if.alloc_tag); else passed++;
        do_alloc(5'd9);    // ignored while clear is high
        checks++; if (rob_if.clear !== 1'b0) $display("FAIL mp_clear_pulse got=%0h exp=0", rob_if.clear); else passed++;
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL mp_no_c2 got=%0h exp=0", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL mp_alloc_ignored got=%0h exp=0", rob_if.alloc_tag); else passed++;
        rob_if.q1_tag = 4'd2;
        rob_if.q2_tag = 4'd3;
        #1;
        checks++; if (rob_if.q1_ready !== 1'b0) $display("FAIL mp_q_tag2 got=%0h exp=0", rob_if.q1_ready); else passed++;
        checks++; if (rob_if.q2_ready !== 1'b0) $display("FAIL mp_q_tag3 got=%0h exp=0", rob_if.q2_ready); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL mp_empty got=%0h exp=0", rob_if.commit_valid); else passed++;
    endtask

    task automatic test_no_dest();
        do_alloc(5'd0);
        do_wb(4'd0, 32'h77, 1'b0, 32'h0);
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1) $display("FAIL nd_valid got=%0h exp=1", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd0) $display("FAIL nd_dest got=%0h exp=0", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.commit_data !== 32'h77) $display("FAIL nd_data got=%0h exp=77", rob_if.commit_data); else passed++;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL nd_drained got=%0h exp=0", rob_if.commit_valid); else passed++;
    endtask

    task automatic test_query_bypass();
        apply_reset();
        for (int i = 0; i < 6; i++) do_alloc(5'(i + 1));
        rob_if.wb_valid = 1'b1;
        rob_if.wb_tag   = 4'd5;
        rob_if.wb_data  = 32'hDEAD;
        rob_if.q1_tag   = 4'd5;
        rob_if.q2_tag   = 4'd4;
        #1;
        checks++; if (rob_if.q1_ready !== BYP) $display("FAIL qb_same_cycle_ready got=%0h exp=%0h", rob_if.q1_ready, BYP); else passed++;
`ifdef ROB_WB_BYPASS_EN
        checks++; if (rob_if.q1_data !== 32'hDEAD) $display("FAIL qb_same_cycle_data got=%0h exp=dead", rob_if.q1_data); else passed++;
`endif
        checks++; if (rob_if.q2_ready !== 1'b0) $display("FAIL qb_busy_pending got=%0h exp=0", rob_if.q2_ready); else passed++;
        tick();
        rob_if.wb_valid = 1'b0;
        #1;
        checks++; if (rob_if.q1_ready !== 1'b1) $display("FAIL qb_next_ready got=%0h exp=1", rob_if.q1_ready); else passed++;
        checks++; if (rob_if.q1_data !== 32'hDEAD) $display("FAIL qb_next_data got=%0h exp=dead", rob_if.q1_data); else passed++;
        rob_if.q2_tag = 4'd9;
        #1;
        checks++; if (rob_if.q2_ready !== 1'b0 || rob_if.q2_data !== 32'd0) $display("FAIL qb_free_entry got=%0h/%0h exp=0/0", rob_if.q2_ready, rob_if.q2_data); else passed++;
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL qb_no_commit got=%0h exp=0", rob_if.commit_valid); else passed++;
    endtask

    task automatic test_freeze();
        do_wb(4'd0, 32'h10, 1'b0, 32'h0);   // head ready: would commit next edge
        rob_if.rdy         = 1'b0;
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_dest  = 5'd7;
        rob_if.wb_valid    = 1'b1;
        rob_if.wb_tag      = 4'd1;
        rob_if.wb_data     = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL fz_commit_%0d got=%0h exp=0", i, rob_if.commit_valid); else passed++;
            checks++; if (rob_if.alloc_tag !== 4'd6) $display("FAIL fz_tail_%0d got=%0h exp=6", i, rob_if.alloc_tag); else passed++;
        end
        rob_if.rdy         = 1'b1;
        rob_if.alloc_valid = 1'b0;
        rob_if.wb_valid    = 1'b0;
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_tag !== 4'd0) $display("FAIL fz_resume got=%0h/%0h exp=1/0", rob_if.commit_valid, rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_data !== 32'h10) $display("FAIL fz_resume_data got=%0h exp=10", rob_if.commit_data); else passed++;
        rob_if.q2_tag = 4'd1;
        #1;
        checks++; if (rob_if.q2_ready !== 1'b0) $display("FAIL fz_wb_ignored got=%0h exp=0", rob_if.q2_ready); else passed++;
    endtask

    task automatic test_reset_mid();
        do_wb(4'd1, 32'h55, 1'b0, 32'h0);
        tick();
        checks++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_data !== 32'h55) $display("FAIL rm_pre got=%0h/%0h exp=1/55", rob_if.commit_valid, rob_if.commit_data); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rob_if.q1_tag = 4'd5;
        #1;
        checks++; if (rob_if.commit_valid !== 1'b0) $display("FAIL rm_valid got=%0h exp=0", rob_if.commit_valid); else passed++;
        checks++; if (rob_if.commit_tag !== 4'd0) $display("FAIL rm_tag got=%0h exp=0", rob_if.commit_tag); else passed++;
        checks++; if (rob_if.commit_data !== 32'd0) $display("FAIL rm_data got=%0h exp=0", rob_if.commit_data); else passed++;
        checks++; if (rob_if.commit_reg_dest !== 5'd0) $display("FAIL rm_dest got=%0h exp=0", rob_if.commit_reg_dest); else passed++;
        checks++; if (rob_if.alloc_tag !== 4'd0) $display("FAIL rm_tail got=%0h exp=0", rob_if.alloc_tag); else passed++;
        checks++; if (rob_if.alloc_ready !== 1'b1) $display("FAIL rm_ready got=%0h exp=1", rob_if.alloc_ready); else passed++;
        checks++; if (rob_if.q1_ready !== 1'b0) $display("FAIL rm_query got=%0h exp=0", rob_if.q1_ready); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_no_dest();
        test_query_bypass();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
